// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment driver for a two-digit score and a lives
// counter, with a flashing lives digit after each lost life.
module score_display #(
  parameter int SCAN_BITS     = 18,
  parameter int BLINK_BITS    = 24,
  parameter int BLINK_FLASHES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score_ones,
  input  logic [3:0] score_tens,
  input  logic [3:0] lives,
  output logic [3:0] an,
  output logic [6:0] ssd,
  output logic       dp
);

  localparam int FLASH_W = $clog2(2 * BLINK_FLASHES + 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(2 * BLINK_FLASHES);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic {IDLE, BLINK} blink_state_e;

  logic [3:0]            ones_q, tens_q, lives_q, lives_prev_q;
  logic [SCAN_BITS-1:0]  scan_q;
  logic [1:0]            sel;
  blink_state_e          state_q, state_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic [FLASH_W-1:0]    flashes_q, flashes_d;
  logic [3:0]            an_q, an_d;
  logic [6:0]            ssd_q, ssd_d;
  logic                  life_loss;
  logic                  lives_blank;

  // Anything that is not a clean 0-9 (including X/Z in simulation) falls to the dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign sel         = scan_q[SCAN_BITS-1 -: 2];
  assign life_loss   = (lives_q < lives_prev_q) && (lives_q <= 4'd9) && (lives_prev_q <= 4'd9);
  assign lives_blank = (state_q == BLINK) && !flashes_q[0];

  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    flashes_d   = flashes_q;
    // A fresh loss outranks everything, including the last flash expiring.
    if (life_loss) begin
      state_d     = BLINK;
      blink_cnt_d = '0;
      flashes_d   = FLASH_LOAD;
    end else if (state_q == BLINK) begin
      blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
      if (blink_cnt_q == '1) begin
        if (flashes_q <= FLASH_W'(1)) begin
          flashes_d = '0;
          state_d   = IDLE;
        end else begin
          flashes_d = flashes_q - FLASH_W'(1);
        end
      end
    end
  end

  always_comb begin
    an_d  = 4'b1111;
    ssd_d = SEG_BLANK;
    case (sel)
      2'd0: begin
        an_d  = 4'b1110;
        ssd_d = seg_decode(ones_q);
      end
      2'd1: begin
        an_d = 4'b1101;
        if (tens_q == 4'd0) ssd_d = SEG_BLANK;
        else                ssd_d = seg_decode(tens_q);
      end
      2'd2: begin
        an_d  = 4'b1011;
        ssd_d = SEG_BLANK;
      end
      default: begin
        an_d = 4'b0111;
        if (lives_blank) ssd_d = SEG_BLANK;
        else             ssd_d = seg_decode(lives_q);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q       <= '0;
      tens_q       <= '0;
      lives_q      <= '0;
      lives_prev_q <= '0;
      scan_q       <= '0;
      state_q      <= IDLE;
      blink_cnt_q  <= '0;
      flashes_q    <= '0;
      an_q         <= 4'b1111;
      ssd_q        <= SEG_BLANK;
    end else begin
      ones_q       <= score_ones;
      tens_q       <= score_tens;
      lives_q      <= lives;
      lives_prev_q <= lives_q;
      scan_q       <= scan_q + SCAN_BITS'(1);
      state_q      <= state_d;
      blink_cnt_q  <= blink_cnt_d;
      flashes_q    <= flashes_d;
      an_q         <= an_d;
      ssd_q        <= ssd_d;
    end
  end

  assign an  = an_q;
  assign ssd = ssd_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a 4-bit scan counter and 8-clock blink
// half-period; digit slots are sampled on the falling edge.
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] score_ones = 4'd0;
  logic [3:0] score_tens = 4'd0;
  logic [3:0] lives      = 4'd0;
  logic [3:0] an;
  logic [6:0] ssd;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;

  logic [6:0] seg_tab [16];
  logic [3:0] an_tab  [4];
  int         win_s   [4];
  int         win_e   [4];

  typedef struct {
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] lv;
    logic [6:0] e_ones;
    logic [6:0] e_tens;
    logic [6:0] e_lives;
  } vec_t;
  vec_t vecs [7];

  score_display #(
    .SCAN_BITS    (4),
    .BLINK_BITS   (3),
    .BLINK_FLASHES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .score_ones(score_ones),
    .score_tens(score_tens),
    .lives     (lives),
    .an        (an),
    .ssd       (ssd),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end else begin
      $display("ok   %s value=%b", name, act);
    end
  endtask

  task automatic wait_an(input logic [3:0] v, input string name);
    int n = 0;
    while (an !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an !== v) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%b required=%b", name, an, v);
    end
  endtask

  // Lives-slot observation across a blink; windows in win_s/win_e are the
  // cycles (counted from the drive of l1) where the digit must be blank.
  task automatic blink_seq(input string name, input logic [3:0] l0, input logic [3:0] l1,
                           input logic [3:0] l2, input int k2);
    int         seen = 0;
    logic [3:0] v;
    logic       blank;
    lives = l0;
    repeat (40) @(negedge clk);
    wait_an(4'b1011, {name, "_align"});
    wait_an(4'b0111, {name, "_align"});
    lives = l1;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      if (an === 4'b0111) begin
        v = (k <= 1) ? l0 : ((k <= k2 + 1) ? l1 : l2);
        blank = 1'b0;
        for (int w = 0; w < 4; w++)
          if (k >= win_s[w] && k <= win_e[w]) blank = 1'b1;
        check($sformatf("%s_k%0d", name, k), {1'b0, ssd}, {1'b0, blank ? BLANK : seg_tab[v]});
        seen++;
      end
      if (k == k2) lives = l2;
    end
    check({name, "_slots"}, 8'(seen), 8'd15);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 16; i++) seg_tab[i] = DASH;
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    vecs[0] = '{4'd2,  4'd4,  4'd3,  7'b0010010, 7'b1001100, 7'b0000110};
    vecs[1] = '{4'd9,  4'd12, 4'd3,  7'b0000100, DASH,       7'b0000110};
    vecs[2] = '{4'd0,  4'd0,  4'd5,  7'b0000001, BLANK,      7'b0100100};
    vecs[3] = '{4'd15, 4'd1,  4'd8,  DASH,       7'b1001111, 7'b0000000};
    vecs[4] = '{4'd6,  4'd10, 4'd9,  7'b0100000, DASH,       7'b0000100};
    vecs[5] = '{4'd8,  4'd5,  4'd14, 7'b0000000, 7'b0100100, DASH};
    vecs[6] = '{4'd1,  4'd3,  4'd3,  7'b1001111, 7'b0000110, 7'b0000110};

    // Asynchronous reset before any clock edge.
    score_ones = 4'd7; score_tens = 4'd0; lives = 4'd3;
    #1 rst = 1'b1;
    #1;
    check("reset_an",  {4'b0, an},  {4'b0, 4'b1111});
    check("reset_ssd", {1'b0, ssd}, {1'b0, BLANK});
    check("reset_dp",  {7'b0, dp},  8'd1);
    @(negedge clk);
    rst = 1'b0;

    // First scan after reset: the ones slot shows the reset-time 0 for one clock.
    for (int k = 1; k <= 32; k++) begin
      int s;
      logic [6:0] e;
      @(negedge clk);
      s = ((k - 1) / 4) % 4;
      case (s)
        0:       e = (k == 1) ? seg_tab[0] : seg_tab[7];
        3:       e = seg_tab[3];
        default: e = BLANK;
      endcase
      check($sformatf("scan_an_k%0d", k),  {4'b0, an},  {4'b0, an_tab[s]});
      check($sformatf("scan_ssd_k%0d", k), {1'b0, ssd}, {1'b0, e});
    end

    for (int i = 0; i < 7; i++) begin
      score_ones = vecs[i].ones; score_tens = vecs[i].tens; lives = vecs[i].lv;
      repeat (3) @(negedge clk);
      wait_an(4'b1110, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_ones", i), {1'b0, ssd}, {1'b0, vecs[i].e_ones});
      check($sformatf("vec%0d_dp", i), {7'b0, dp}, 8'd1);
      wait_an(4'b1101, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tens", i), {1'b0, ssd}, {1'b0, vecs[i].e_tens});
      wait_an(4'b1011, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_blank", i), {1'b0, ssd}, {1'b0, BLANK});
      wait_an(4'b0111, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_lives", i), {1'b0, ssd}, {1'b0, vecs[i].e_lives});
    end

    // Plain blink 3 -> 2.
    win_s = '{3, 19, 0, 0}; win_e = '{10, 26, -1, -1};
    blink_seq("blink", 4'd3, 4'd2, 4'd2, 1000);
    // Second loss halfway through restarts the sequence.
    win_s = '{3, 15, 31, 0}; win_e = '{10, 22, 38, -1};
    blink_seq("restart", 4'd3, 4'd2, 4'd1, 12);
    // Second loss lands on the final flash expiry.
    win_s = '{3, 19, 35, 51}; win_e = '{10, 26, 42, 58};
    blink_seq("collide", 4'd3, 4'd2, 4'd1, 32);

    // Reset between clock edges in the middle of a blink.
    lives = 4'd3;
    repeat (40) @(negedge clk);
    lives = 4'd2;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_an",  {4'b0, an},  {4'b0, 4'b1111});
    check("midrst_ssd", {1'b0, ssd}, {1'b0, BLANK});
    check("midrst_dp",  {7'b0, dp},  8'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) check("midrst_sel0", {4'b0, an}, {4'b0, 4'b1110});
      if (an === 4'b0111) begin
        check($sformatf("midrst_lives_k%0d", k), {1'b0, ssd}, {1'b0, seg_tab[2]});
        seen++;
      end
    end
    check("midrst_slots", 8'(seen), 8'd8);

    // New game 0 -> 3 must not blink.
    rst = 1'b1;
    lives = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    lives = 4'd3;
    repeat (2) @(negedge clk);
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (an === 4'b0111) begin
        check($sformatf("newgame_k%0d", k), {1'b0, ssd}, {1'b0, seg_tab[3]});
        seen++;
      end
    end
    check("newgame_slots", {7'b0, (seen >= 8)}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
